// File: rtl/game_pkg.sv
// ============================================================================
// Module  : game_pkg
// Brief   : Shared constants, kind/state encodings and LFSR step function.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

   localparam int          COL_H    = 100;
   localparam int          THICK    = 20;
   localparam logic [15:0] SEED_DEF = 16'hACE1;

   localparam logic [1:0] KIND_BOT = 2'd0;
   localparam logic [1:0] KIND_TOP = 2'd1;
   localparam logic [1:0] KIND_MID = 2'd2;
   localparam logic [1:0] KIND_ALL = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LEAD = 2'd1,
      S_WALL = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   // Fibonacci, shift left, taps 16/14/13/11
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

endpackage

`default_nettype wire

// File: rtl/wall_column_gen_lfsr16.sv
// ============================================================================
// Module  : lfsr16
// Brief   : 16-bit Fibonacci LFSR with synchronous load and single step.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr16
   import game_pkg::*;
#(
   parameter logic [15:0] RST_VAL = game_pkg::SEED_DEF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        load,
   input  logic [15:0] load_val,
   input  logic        step,
   output logic [15:0] q
);

   logic [15:0] r_q;

   always_ff @(posedge clk) begin
      if (!resetn)
         r_q <= RST_VAL;
      else if (load)
         r_q <= load_val;
      else if (step)
         r_q <= lfsr_next(r_q);
   end

   assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/wall_column_gen.sv
// ============================================================================
// Module  : wall_column_gen
// Brief   : Seeded wall-column generator with a one-entry prefetch buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wall_column_gen
   import game_pkg::*;
#(
   parameter int          COL_H    = game_pkg::COL_H,
   parameter int          THICK    = game_pkg::THICK,
   parameter int          WALL_W   = 4,
   parameter int          SPACING  = 8,
   parameter int          LEAD     = 40,
   parameter logic [15:0] SEED_DEF = game_pkg::SEED_DEF
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [15:0]      seed,
   input  logic             req,
   output logic             col_valid,
   output logic [COL_H-1:0] col_data,
   output logic             col_is_wall,
   output logic [1:0]       col_kind,
   output logic [15:0]      col_count,
   output logic             underrun
);

   localparam int c_LW = $clog2(LEAD + 1);
   localparam int c_WW = $clog2(WALL_W + 1);
   localparam int c_SW = $clog2(SPACING + 1);
   localparam logic [c_LW-1:0] c_LEAD_LAST = c_LW'(LEAD - 1);
   localparam logic [c_WW-1:0] c_WALL_LAST = c_WW'(WALL_W - 1);
   localparam logic [c_SW-1:0] c_GAP_LAST  = c_SW'(SPACING - 1);

   localparam logic [COL_H-1:0] c_BOT = {{(COL_H-THICK){1'b0}}, {THICK{1'b1}}};
   localparam logic [COL_H-1:0] c_TOP = {{THICK{1'b1}}, {(COL_H-THICK){1'b0}}};
   localparam logic [COL_H-1:0] c_MID = {{(COL_H-COL_H/2-20){1'b0}}, {40{1'b1}}, {(COL_H/2-20){1'b0}}};

   state_t            r_state, w_state_nxt;
   logic [c_LW-1:0]   r_lead_cnt;
   logic [c_WW-1:0]   r_slab_cnt;
   logic [c_SW-1:0]   r_gap_cnt;
   logic [1:0]        r_kind;
   logic              r_g1;
   logic              r_col_valid;
   logic [COL_H-1:0]  r_col_data;
   logic              r_col_is_wall;
   logic [1:0]        r_col_kind;
   logic [15:0]       r_col_count;
   logic              r_underrun;

   logic [15:0]       w_lfsr_q;
   logic [15:0]       w_lfsr_nxt;
   logic [15:0]       w_load_val;
   logic              w_gen_g1;
   logic              w_gen_g2;
   logic              w_slab_start;
   logic [COL_H-1:0]  w_col;

   // G1 only fires with the buffer empty and no column already in flight
   assign w_gen_g1     = (r_state != S_IDLE) && !r_col_valid && !r_g1;
   assign w_gen_g2     = r_g1;
   assign w_slab_start = w_gen_g1 && (r_state == S_WALL) && (r_slab_cnt == '0);
   assign w_lfsr_nxt   = lfsr_next(w_lfsr_q);
   assign w_load_val   = (seed == 16'h0000) ? SEED_DEF : seed;

   lfsr16 #(
      .RST_VAL (SEED_DEF)
   ) u_lfsr (
      .clk      (clk),
      .resetn   (resetn),
      .load     (start),
      .load_val (w_load_val),
      .step     (w_slab_start && !start),
      .q        (w_lfsr_q)
   );

   always_comb begin
      w_col = '0;
      if (r_state == S_WALL) begin
         case (r_kind)
            KIND_BOT: w_col = c_BOT;
            KIND_TOP: w_col = c_TOP;
            KIND_MID: w_col = c_MID;
            default:  w_col = c_BOT | c_TOP;
         endcase
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (start) begin
         w_state_nxt = S_LEAD;
      end else if (w_gen_g2) begin
         case (r_state)
            S_LEAD:  if (r_lead_cnt == c_LEAD_LAST) w_state_nxt = S_WALL;
            S_WALL:  if (r_slab_cnt == c_WALL_LAST) w_state_nxt = S_GAP;
            S_GAP:   if (r_gap_cnt  == c_GAP_LAST)  w_state_nxt = S_WALL;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!resetn || start) begin
         r_lead_cnt    <= '0;
         r_slab_cnt    <= '0;
         r_gap_cnt     <= '0;
         r_kind        <= KIND_BOT;
         r_g1          <= 1'b0;
         r_col_valid   <= 1'b0;
         r_col_data    <= '0;
         r_col_is_wall <= 1'b0;
         r_col_kind    <= KIND_BOT;
         r_col_count   <= '0;
         r_underrun    <= 1'b0;
      end else begin
         if (req) begin
            if (r_col_valid) begin
               r_col_valid <= 1'b0;
               if (r_col_count != 16'hFFFF)
                  r_col_count <= r_col_count + 16'd1;
            end else begin
               r_underrun <= 1'b1;
            end
         end
         if (w_slab_start)
            r_kind <= w_lfsr_nxt[1:0];
         r_g1 <= w_gen_g1;
         if (w_gen_g2) begin
            r_col_valid   <= 1'b1;
            r_col_data    <= w_col;
            r_col_is_wall <= |w_col;
            r_col_kind    <= (r_state == S_WALL) ? r_kind : KIND_BOT;
            case (r_state)
               S_LEAD:  r_lead_cnt <= (r_lead_cnt == c_LEAD_LAST) ? '0 : r_lead_cnt + 1'b1;
               S_WALL:  r_slab_cnt <= (r_slab_cnt == c_WALL_LAST) ? '0 : r_slab_cnt + 1'b1;
               S_GAP:   r_gap_cnt  <= (r_gap_cnt  == c_GAP_LAST)  ? '0 : r_gap_cnt  + 1'b1;
               default: ;
            endcase
         end
      end
   end

   assign col_valid   = r_col_valid;
   assign col_data    = r_col_data;
   assign col_is_wall = r_col_is_wall;
   assign col_kind    = r_col_kind;
   assign col_count   = r_col_count;
   assign underrun    = r_underrun;

endmodule

`default_nettype wire
